inj_scan_seq: RTL and testbench
===============================

# inj_scan_seq

Injection-scan sequencer in the CLK40 domain. It generates a programmable train of gated injection cycles for the monolithic-pixel test system. Each repetition produces an optional gray-counter reset, a TDC/timestamp gate window and an injection pulse inside that window. It replaces independent free-running pulse generators with one sequenced source whose outputs feed the chip injection line, the TDC external enable and the RST_GRAY driver. Readout back-pressure can pause the sequence between repetitions.

## Interface
- CNT_W, 16, width of all timing fields and the repetition counter
- CLK40  in  1  sole clock; all logic on rising edge
- nRST  in  1  synchronous, active-low reset
- START  in  1  one-cycle request; accepted only in IDLE
- ABORT  in  1  stop immediately; priority over START
- PAUSE  in  1  back-pressure (FIFO_NEAR_FULL); holds between repetitions
- EN_GRAY_RST  in  1  assert RST_GRAY at the start of each repetition
- REPEAT  in  CNT_W  repetitions; 0 = continuous until ABORT
- GATE_WIDTH  in  CNT_W  gate high cycles per repetition
- INJ_DELAY  in  CNT_W  cycles from gate rise to injection rise
- INJ_WIDTH  in  CNT_W  injection high cycles
- PERIOD  in  CNT_W  cycles per repetition
- GATE  out  1  TDC/timestamp gate (registered)
- INJECTION  out  1  injection pulse (registered)
- RST_GRAY  out  1  gray-counter reset (registered)
- BUSY  out  1  high from accepted START until return to IDLE
- DONE  out  1  one-cycle pulse on normal completion
- ABORTED  out  1  sticky; set by ABORT while busy, cleared by next accepted START
- REP_CNT  out  CNT_W  completed repetitions

## Operation
- States: IDLE, ARM, GATE, GAP, HOLD, FIN.
- START in IDLE latches all config fields. Later config changes are ignored until the next START. REP_CNT clears to 0 on acceptance.
- Effective period: P = max(PERIOD, GATE_WIDTH+2).
- Each repetition has a local counter t:
  - ARM: t=0. RST_GRAY = EN_GRAY_RST.
  - GATE: t = 1..GATE_WIDTH. GATE high. If GATE_WIDTH = 0, the FSM skips straight to GAP.
  - GAP: t = GATE_WIDTH+1 .. P-1. All outputs low.
- INJECTION is high when t ∈ [1+INJ_DELAY, INJ_DELAY+INJ_WIDTH] AND GATE is high. Any part of the window outside the gate is clipped, never extended.
- End of repetition (t = P-1):
  - REP_CNT increments. It wraps at 2^CNT_W-1 → 0 in continuous mode.
  - If REPEAT ≠ 0 and REP_CNT+1 = REPEAT → FIN.
  - Else if PAUSE = 1 → HOLD.
  - Else → ARM.
- HOLD: all outputs low; BUSY stays high. Go to ARM in the cycle after PAUSE is sampled low.
- FIN: DONE = 1 for one cycle, then IDLE.
- ABORT in any non-IDLE state:
  - Next cycle is IDLE with GATE, INJECTION, RST_GRAY and BUSY all 0.
  - ABORTED is set; DONE is not pulsed; REP_CNT holds its value.
  - ABORT in IDLE has no effect.
- START while BUSY is ignored. START together with ABORT in IDLE is ignored.

## Timing
- Reset (nRST = 0 at an edge): state IDLE, all outputs 0, REP_CNT = 0, ABORTED = 0, latched config = 0.
- With START high in cycle c:
  - BUSY = 1 from c+1.
  - RST_GRAY in cycle c+1.
  - GATE in cycles c+2 .. c+1+GATE_WIDTH.
  - INJECTION in cycles c+2+INJ_DELAY .. c+1+INJ_DELAY+INJ_WIDTH, clipped as above.
- Repetition k starts (ARM) at c+1+k·P when there is no pause.
- Last repetition of n: DONE in cycle c+1+n·P; BUSY = 0 from c+2+n·P.
- REP_CNT updates in the cycle after t = P-1.
- A PAUSE rise mid-repetition does not shorten the current repetition.
- HOLD entered at cycle h and PAUSE first sampled low at cycle p: ARM at p+1.
- nRST mid-sequence behaves like power-on reset; the next cycle has all outputs low.

## Test plan
- Basic: REPEAT=3, PERIOD=20, GATE_WIDTH=10, INJ_DELAY=2, INJ_WIDTH=4, EN_GRAY_RST=1, START at c=5 → expected:
  - RST_GRAY at 6, 26, 46.
  - GATE 7–16, 27–36, 47–56.
  - INJECTION 9–12, 29–32, 49–52.
  - DONE at 66; REP_CNT = 3.
- Clipping and short period: GATE_WIDTH=5, INJ_DELAY=3, INJ_WIDTH=10, PERIOD=4 → P = 7; INJECTION high for only 2 cycles per repetition; repetitions start every 7 cycles.
- Pause: PAUSE held high across the end of repetition 1 for 15 cycles → HOLD with outputs low, BUSY = 1; ARM one cycle after PAUSE falls; total repetitions still = REPEAT.
- Abort: ABORT during the GATE phase of repetition 2 → next cycle all outputs 0, BUSY = 0, ABORTED = 1, no DONE, REP_CNT = 1. A subsequent START clears ABORTED.
- Continuous wrap: CNT_W=4, REPEAT=0, PERIOD=3 → REP_CNT counts 0..15 then 0, BUSY never drops until ABORT. A START issued while busy is ignored.
- Reset mid-run: nRST low for 1 cycle during INJECTION → all outputs 0 on the following cycle, REP_CNT = 0, IDLE; a fresh START then runs correctly.

Source files
------------

// File: rtl/inj_scan_seq.sv
// Injection-scan sequencer: gated RST_GRAY / GATE / INJECTION train
// with repeat count, back-pressure hold and abort, all in CLK40.
module inj_scan_seq #(
  parameter int CNT_W = 16
) (
  input  logic             CLK40,
  input  logic             nRST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             PAUSE,
  input  logic             EN_GRAY_RST,
  input  logic [CNT_W-1:0] REPEAT,
  input  logic [CNT_W-1:0] GATE_WIDTH,
  input  logic [CNT_W-1:0] INJ_DELAY,
  input  logic [CNT_W-1:0] INJ_WIDTH,
  input  logic [CNT_W-1:0] PERIOD,
  output logic             GATE,
  output logic             INJECTION,
  output logic             RST_GRAY,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORTED,
  output logic [CNT_W-1:0] REP_CNT
);

  localparam int TW = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_GAP,
    S_HOLD,
    S_FIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [TW-1:0]    t;
  logic [TW-1:0]    t_n;
  logic [TW-1:0]    per;
  logic [TW-1:0]    inj_lo;
  logic [TW-1:0]    inj_hi;
  logic [CNT_W-1:0] rep;
  logic [CNT_W-1:0] gw;
  logic             en_gray;

  logic [TW-1:0]    gw_p2;
  logic [TW-1:0]    per_x;
  logic [TW-1:0]    cfg_per;
  logic [TW-1:0]    cfg_lo;
  logic [TW-1:0]    cfg_hi;

  logic             accept;
  logic             rep_end;
  logic             last_rep;
  logic [CNT_W-1:0] rep_cnt_n;
  logic             aborted_n;

  logic             gate_d;
  logic             inj_d;
  logic             rst_gray_d;
  logic             busy_d;
  logic             done_d;
  logic             en_gray_n;

  // One extra bit keeps GATE_WIDTH+2 and DELAY+WIDTH from wrapping.
  always_comb begin
    gw_p2   = {1'b0, GATE_WIDTH} + TW'(2);
    per_x   = {1'b0, PERIOD};
    cfg_per = (per_x > gw_p2) ? per_x : gw_p2;
    cfg_lo  = {1'b0, INJ_DELAY} + TW'(1);
    cfg_hi  = {1'b0, INJ_DELAY} + {1'b0, INJ_WIDTH};
  end

  always_comb begin
    accept   = (state == S_IDLE) && START && !ABORT;
    rep_end  = (state == S_GAP) && (t == per - TW'(1));
    last_rep = (rep != '0) && ((REP_CNT + CNT_W'(1)) == rep);
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    if ((state != S_IDLE) && ABORT) begin
      state_n = S_IDLE;
      t_n     = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state_n = S_ARM;
            t_n     = '0;
          end
        end
        S_ARM: begin
          state_n = (gw == '0) ? S_GAP : S_GATE;
          t_n     = TW'(1);
        end
        S_GATE: begin
          t_n = t + TW'(1);
          if (t == {1'b0, gw}) state_n = S_GAP;
        end
        S_GAP: begin
          if (rep_end) begin
            t_n = '0;
            if (last_rep)   state_n = S_FIN;
            else if (PAUSE) state_n = S_HOLD;
            else            state_n = S_ARM;
          end else begin
            t_n = t + TW'(1);
          end
        end
        S_HOLD: begin
          if (!PAUSE) begin
            state_n = S_ARM;
            t_n     = '0;
          end
        end
        S_FIN: begin
          state_n = S_IDLE;
          t_n     = '0;
        end
        default: begin
          state_n = S_IDLE;
          t_n     = '0;
        end
      endcase
    end
  end

  always_comb begin
    rep_cnt_n = REP_CNT;
    aborted_n = ABORTED;
    if (accept) begin
      rep_cnt_n = '0;
      aborted_n = 1'b0;
    end else if ((state != S_IDLE) && ABORT) begin
      aborted_n = 1'b1;
    end else if (rep_end) begin
      rep_cnt_n = REP_CNT + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they register cleanly.
  always_comb begin
    en_gray_n  = accept ? EN_GRAY_RST : en_gray;
    gate_d     = (state_n == S_GATE);
    inj_d      = gate_d && (t_n >= inj_lo) && (t_n <= inj_hi);
    rst_gray_d = (state_n == S_ARM) && en_gray_n;
    busy_d     = (state_n != S_IDLE);
    done_d     = (state_n == S_FIN);
  end

  always_ff @(posedge CLK40) begin
    if (!nRST) begin
      state     <= S_IDLE;
      t         <= '0;
      per       <= '0;
      inj_lo    <= '0;
      inj_hi    <= '0;
      rep       <= '0;
      gw        <= '0;
      en_gray   <= 1'b0;
      GATE      <= 1'b0;
      INJECTION <= 1'b0;
      RST_GRAY  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ABORTED   <= 1'b0;
      REP_CNT   <= '0;
    end else begin
      state     <= state_n;
      t         <= t_n;
      GATE      <= gate_d;
      INJECTION <= inj_d;
      RST_GRAY  <= rst_gray_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ABORTED   <= aborted_n;
      REP_CNT   <= rep_cnt_n;
      if (accept) begin
        per     <= cfg_per;
        inj_lo  <= cfg_lo;
        inj_hi  <= cfg_hi;
        rep     <= REPEAT;
        gw      <= GATE_WIDTH;
        en_gray <= EN_GRAY_RST;
      end
    end
  end

endmodule

// File: tb/tb_inj_scan_seq.sv
// Bench for inj_scan_seq: directed plan scenarios plus random traffic
// against a cycle-arithmetic reference model.
module tb_inj_scan_seq;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pause = 1'b0;
  logic        en = 1'b0;
  logic [15:0] rep = '0;
  logic [15:0] gw = '0;
  logic [15:0] dly = '0;
  logic [15:0] wid = '0;
  logic [15:0] per = '0;
  logic        gate, inj, rst_gray, busy, done, aborted;
  logic [15:0] rep_cnt;

  logic        start4 = 1'b0;
  logic        abort4 = 1'b0;
  logic        pause4 = 1'b0;
  logic        en4 = 1'b0;
  logic [3:0]  rep4 = 4'd0;
  logic [3:0]  gw4 = 4'd1;
  logic [3:0]  dly4 = 4'd0;
  logic [3:0]  wid4 = 4'd1;
  logic [3:0]  per4 = 4'd3;
  logic        gate4, inj4, rst_gray4, busy4, done4, aborted4;
  logic [3:0]  rep_cnt4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_busy, m_fin, m_hold, m_ab, m_cnt, m_org;
  int m_rep, m_gw, m_d, m_w, m_p, m_en;
  int inj_n, gate_n, rg_n, done_n, last_done;

  always #5 clk = ~clk;

  inj_scan_seq #(.CNT_W(16)) u_dut (
    .CLK40(clk), .nRST(nrst), .START(start), .ABORT(abort),
    .PAUSE(pause), .EN_GRAY_RST(en), .REPEAT(rep),
    .GATE_WIDTH(gw), .INJ_DELAY(dly), .INJ_WIDTH(wid),
    .PERIOD(per), .GATE(gate), .INJECTION(inj),
    .RST_GRAY(rst_gray), .BUSY(busy), .DONE(done),
    .ABORTED(aborted), .REP_CNT(rep_cnt)
  );

  inj_scan_seq #(.CNT_W(4)) u_w4 (
    .CLK40(clk), .nRST(nrst), .START(start4), .ABORT(abort4),
    .PAUSE(pause4), .EN_GRAY_RST(en4), .REPEAT(rep4),
    .GATE_WIDTH(gw4), .INJ_DELAY(dly4), .INJ_WIDTH(wid4),
    .PERIOD(per4), .GATE(gate4), .INJECTION(inj4),
    .RST_GRAY(rst_gray4), .BUSY(busy4), .DONE(done4),
    .ABORTED(aborted4), .REP_CNT(rep_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d got %0h exp %0h", tag, cyc, a, e);
    end
  endtask

  // Reference: each repetition is an origin cycle plus offset t.
  task automatic model_edge();
    if (!nrst) begin
      m_busy = 0; m_fin = 0; m_hold = 0; m_ab = 0; m_cnt = 0;
      m_org = 0; m_rep = 0; m_gw = 0; m_d = 0; m_w = 0;
      m_p = 0; m_en = 0;
    end else if (m_busy != 0 && abort) begin
      m_busy = 0; m_fin = 0; m_hold = 0; m_ab = 1;
    end else if (m_busy == 0) begin
      if (start && !abort) begin
        m_rep = int'(rep); m_gw = int'(gw); m_d = int'(dly);
        m_w = int'(wid); m_en = int'(en);
        m_p = (int'(per) > m_gw + 2) ? int'(per) : m_gw + 2;
        m_busy = 1; m_fin = 0; m_hold = 0; m_ab = 0;
        m_cnt = 0; m_org = cyc + 1;
      end
    end else if (m_fin != 0) begin
      m_busy = 0; m_fin = 0;
    end else if (m_hold != 0) begin
      if (!pause) begin
        m_hold = 0; m_org = cyc + 1;
      end
    end else if (cyc - m_org == m_p - 1) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (m_rep != 0 && m_cnt == m_rep) m_fin = 1;
      else if (pause) m_hold = 1;
      else m_org = cyc + 1;
    end
  endtask

  task automatic check_all();
    int t;
    int act;
    int e_g, e_i, e_r;
    t   = cyc - m_org;
    act = (m_busy != 0 && m_fin == 0 && m_hold == 0) ? 1 : 0;
    e_r = (act != 0 && t == 0 && m_en != 0) ? 1 : 0;
    e_g = (act != 0 && t >= 1 && t <= m_gw) ? 1 : 0;
    e_i = (e_g != 0 && t >= m_d + 1 && t <= m_d + m_w) ? 1 : 0;
    chk("gate", 32'(gate), 32'(e_g));
    chk("injection", 32'(inj), 32'(e_i));
    chk("rst_gray", 32'(rst_gray), 32'(e_r));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_busy != 0 && m_fin != 0));
    chk("aborted", 32'(aborted), 32'(m_ab));
    chk("rep_cnt", 32'(rep_cnt), 32'(m_cnt));
    if (inj === 1'b1) inj_n++;
    if (gate === 1'b1) gate_n++;
    if (rst_gray === 1'b1) rg_n++;
    if (done === 1'b1) begin
      done_n++;
      last_done = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    inj_n = 0; gate_n = 0; rg_n = 0; done_n = 0; last_done = -1;
  endtask

  task automatic set_cfg(input int r, input int g, input int d,
                         input int w, input int p, input logic e);
    rep = 16'(r); gw = 16'(g); dly = 16'(d);
    wid = 16'(w); per = 16'(p); en = e;
  endtask

  task automatic pulse_start(output int cs);
    cs = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int cs;

  initial begin
    clr_counts();
    ticks(2);
    nrst = 1'b1;
    ticks(3);

    // basic
    set_cfg(3, 10, 2, 4, 20, 1'b1);
    clr_counts();
    pulse_start(cs);
    set_cfg(7, 1, 0, 1, 3, 1'b0);
    ticks(69);
    chk("basic_done_cyc", 32'(last_done - cs), 32'd61);
    chk("basic_done_n", 32'(done_n), 32'd1);
    chk("basic_inj_n", 32'(inj_n), 32'd12);
    chk("basic_gate_n", 32'(gate_n), 32'd30);
    chk("basic_rg_n", 32'(rg_n), 32'd3);
    chk("basic_repcnt", 32'(rep_cnt), 32'd3);

    // clipping, effective period 7
    set_cfg(2, 5, 3, 10, 4, 1'b0);
    clr_counts();
    pulse_start(cs);
    ticks(20);
    chk("clip_inj_n", 32'(inj_n), 32'd4);
    chk("clip_done_cyc", 32'(last_done - cs), 32'd15);

    // pause across end of first repetition
    set_cfg(3, 10, 2, 4, 20, 1'b1);
    clr_counts();
    pulse_start(cs);
    ticks(14);
    pause = 1'b1;
    ticks(15);
    pause = 1'b0;
    ticks(50);
    chk("pause_done_cyc", 32'(last_done - cs), 32'd71);
    chk("pause_repcnt", 32'(rep_cnt), 32'd3);
    chk("pause_gate_n", 32'(gate_n), 32'd30);

    // abort in GATE of second repetition
    clr_counts();
    pulse_start(cs);
    ticks(24);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_repcnt", 32'(rep_cnt), 32'd1);
    ticks(5);
    chk("abort_no_done", 32'(done_n), 32'd0);
    pulse_start(cs);
    chk("restart_clears", 32'(aborted), 32'd0);
    ticks(70);

    // reset during injection
    pulse_start(cs);
    ticks(4);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("rst_inj", 32'(inj), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_repcnt", 32'(rep_cnt), 32'd0);
    ticks(2);
    clr_counts();
    pulse_start(cs);
    ticks(65);
    chk("rst_rerun_done", 32'(last_done - cs), 32'd61);

    // continuous wrap on the 4-bit instance, P = 3
    cs = cyc;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      chk("w4_busy", 32'(busy4), 32'd1);
      chk("w4_repcnt", 32'(rep_cnt4), 32'((i / 3) % 16));
      chk("w4_gate", 32'(gate4), 32'((i % 3) == 1));
      start4 = (i == 30);
      tick();
    end
    start4 = 1'b0;
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    chk("w4_abort_busy", 32'(busy4), 32'd0);
    chk("w4_aborted", 32'(aborted4), 32'd1);
    chk("w4_hold_cnt", 32'(rep_cnt4), 32'd4);
    chk("w4_no_done", 32'(done4), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      nrst  = ($urandom_range(0, 499) != 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      pause = ($urandom_range(0, 5) == 0);
      set_cfg($urandom_range(0, 4), $urandom_range(0, 6),
              $urandom_range(0, 8), $urandom_range(0, 8),
              $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      tick();
    end
    nrst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pause = 1'b0;
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
